// File: rtl/clock_enable_gen.sv
// Clock-enable strobe generator for the SAP-1 core: free-run, fixed-ratio divide,
// debounced single-step and stop modes, plus a sticky halt captured from the CPU.
module clock_enable_gen #(
  parameter int DIV_RATIO       = 100000000,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] mode,
  input  logic       step_btn,
  input  logic       halt,
  output logic       clk_en,
  output logic       halted
);

  localparam int DIV_W = (DIV_RATIO > 1) ? $clog2(DIV_RATIO) : 1;
  localparam int DEB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(DIV_RATIO - 1);
  localparam logic [DIV_W-1:0] DIV_ZERO = {DIV_W{1'b0}};
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DEB_W-1:0] DEB_ZERO = {DEB_W{1'b0}};
  localparam logic [DEB_W-1:0] DEB_ONE  = DEB_W'(1);

  localparam logic [1:0] MODE_RUN  = 2'd0;
  localparam logic [1:0] MODE_DIV  = 2'd1;
  localparam logic [1:0] MODE_STEP = 2'd2;
  localparam logic [1:0] MODE_STOP = 2'd3;

  logic [DIV_W-1:0] div_cnt_r;
  logic [DIV_W-1:0] div_cnt_s;
  logic             div_pulse_s;
  logic [1:0]       mode_prev_r;

  logic             sync1_r;
  logic             sync2_r;
  logic             deb_level_r;
  logic             deb_level_s;
  logic             deb_edge_r;
  logic [DEB_W-1:0] deb_cnt_r;
  logic [DEB_W-1:0] deb_cnt_s;
  logic             step_req_s;

  logic             halted_s;
  logic             clk_en_s;

  // Divider next count; the pulse is requested on the edge the counter lands on zero,
  // and the first mode-1 cycle after any other mode only parks the counter at full period.
  always_comb begin
    div_cnt_s = DIV_LOAD;
    if ((mode != MODE_DIV) || (mode_prev_r != MODE_DIV)) begin
      div_cnt_s = DIV_LOAD;
    end else if (div_cnt_r == DIV_ZERO) begin
      div_cnt_s = DIV_LOAD;
    end else begin
      div_cnt_s = div_cnt_r - DIV_ONE;
    end
    div_pulse_s = (div_cnt_s == DIV_ZERO);
  end

  // Debouncer: a new synchronised level must persist for DEBOUNCE_CYCLES samples.
  always_comb begin
    deb_level_s = deb_level_r;
    deb_cnt_s   = DEB_ZERO;
    if (sync2_r == deb_level_r) begin
      deb_cnt_s = DEB_ZERO;
    end else if (deb_cnt_r == DEB_LAST) begin
      deb_level_s = sync2_r;
      deb_cnt_s   = DEB_ZERO;
    end else begin
      deb_cnt_s = deb_cnt_r + DEB_ONE;
    end
    step_req_s = deb_level_r & ~deb_edge_r;
  end

  // Output selection; halt, current or already captured, masks every mode.
  always_comb begin
    halted_s = halted | halt;
    clk_en_s = 1'b0;
    if (halted_s) begin
      clk_en_s = 1'b0;
    end else begin
      case (mode)
        MODE_RUN:  clk_en_s = 1'b1;
        MODE_DIV:  clk_en_s = div_pulse_s;
        MODE_STEP: clk_en_s = step_req_s;
        MODE_STOP: clk_en_s = 1'b0;
        default:   clk_en_s = 1'b0;
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_r   <= DIV_LOAD;
      mode_prev_r <= MODE_RUN;
      sync1_r     <= 1'b0;
      sync2_r     <= 1'b0;
      deb_level_r <= 1'b0;
      deb_edge_r  <= 1'b0;
      deb_cnt_r   <= DEB_ZERO;
      halted      <= 1'b0;
      clk_en      <= 1'b0;
    end else begin
      div_cnt_r   <= div_cnt_s;
      mode_prev_r <= mode;
      sync1_r     <= step_btn;
      sync2_r     <= sync1_r;
      deb_level_r <= deb_level_s;
      deb_edge_r  <= deb_level_r;
      deb_cnt_r   <= deb_cnt_s;
      halted      <= halted_s;
      clk_en      <= clk_en_s;
    end
  end

endmodule

// File: tb/tb_clock_enable_gen.sv
// Self-checking bench for clock_enable_gen: directed scenarios plus random mode/button
// traffic compared cycle by cycle against a history-based reference model.
module tb_clock_enable_gen;

  localparam int DIV = 4;
  localparam int DEB = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, step_btn, halt, clk_en, halted;
  logic [1:0] mode;
  logic       u1_rst, u1_btn, u1_halt, u1_clk_en, u1_halted;
  logic [1:0] u1_mode;

  clock_enable_gen #(.DIV_RATIO(DIV), .DEBOUNCE_CYCLES(DEB)) dut (
    .clk(clk), .rst(rst), .mode(mode), .step_btn(step_btn), .halt(halt),
    .clk_en(clk_en), .halted(halted)
  );

  clock_enable_gen #(.DIV_RATIO(1), .DEBOUNCE_CYCLES(DEB)) dut1 (
    .clk(clk), .rst(u1_rst), .mode(u1_mode), .step_btn(u1_btn), .halt(u1_halt),
    .clk_en(u1_clk_en), .halted(u1_halted)
  );

  int n_assert = 0;
  int n_fail   = 0;
  int pulses_seen = 0;

  // Reference model state: edges since reset release, raw button samples and
  // debounced level after each such edge, length of the current mode-1 run.
  int edge_idx = 0;
  int div_run  = 0;
  bit halted_m = 1'b0;
  bit raw_hist[$];
  bit deb_hist[$];

  function automatic bit seen_at(int i);
    // The debouncer sees the raw level two edges late; zeros before that.
    return (i >= 2) ? raw_hist[i-2] : 1'b0;
  endfunction

  task automatic check(input string tag, input logic observed, input logic expected);
    n_assert++;
    assert (observed === expected)
      else begin
        n_fail++;
        $error("FAIL %s at %0t: observed %b expected %b", tag, $time, observed, expected);
      end
  endtask

  task automatic check_int(input string tag, input int observed, input int expected);
    n_assert++;
    assert (observed === expected)
      else begin
        n_fail++;
        $error("FAIL %s at %0t: observed %0d expected %0d", tag, $time, observed, expected);
      end
  endtask

  task automatic model_edge(input logic r, input logic [1:0] m, input logic b,
                            input logic h, output logic exp_en);
    int  k;
    bit  deb_prev, edge_prev, accept, step;
    if (r) begin
      edge_idx = 0;
      div_run  = 0;
      halted_m = 1'b0;
      raw_hist.delete();
      deb_hist.delete();
      exp_en   = 1'b0;
    end else begin
      k = edge_idx;
      raw_hist.push_back(b);
      deb_prev  = (k >= 1) ? deb_hist[k-1] : 1'b0;
      edge_prev = (k >= 2) ? deb_hist[k-2] : 1'b0;
      accept = 1'b1;
      for (int j = 0; j < DEB; j++) begin
        if ((k - j) < 0) accept = 1'b0;
        else if (seen_at(k - j) == deb_prev) accept = 1'b0;
      end
      deb_hist.push_back(accept ? ~deb_prev : deb_prev);
      step = deb_prev & ~edge_prev;
      div_run  = (m == 2'd1) ? div_run + 1 : 0;
      halted_m = halted_m | h;
      if (halted_m) exp_en = 1'b0;
      else begin
        case (m)
          2'd0:    exp_en = 1'b1;
          2'd1:    exp_en = ((div_run % DIV) == 0);
          2'd2:    exp_en = step;
          default: exp_en = 1'b0;
        endcase
      end
      edge_idx++;
    end
  endtask

  task automatic cyc(input logic r, input logic [1:0] m, input logic b, input logic h,
                     input int count);
    logic exp_en;
    for (int c = 0; c < count; c++) begin
      rst = r; mode = m; step_btn = b; halt = h;
      @(posedge clk);
      #1;
      model_edge(r, m, b, h, exp_en);
      check("clk_en", clk_en, exp_en);
      check("halted", halted, halted_m);
      if (clk_en === 1'b1) pulses_seen++;
    end
  endtask

  initial begin
    u1_rst = 1'b1; u1_mode = 2'd0; u1_btn = 1'b0; u1_halt = 1'b0;

    cyc(1'b1, 2'd0, 1'b0, 1'b0, 2);

    // Divide by 4 from reset release: pulses on edges 4, 8, 12, 16.
    pulses_seen = 0;
    cyc(1'b0, 2'd1, 1'b0, 1'b0, 17);
    check_int("div4_pulse_count", pulses_seen, 4);

    // Free-run then divide: full period restarts on entry.
    cyc(1'b0, 2'd0, 1'b0, 1'b0, 10);
    pulses_seen = 0;
    cyc(1'b0, 2'd1, 1'b0, 1'b0, 12);
    check_int("switch_pulse_count", pulses_seen, 3);

    // Bouncy press then clean hold: a single pulse on the 6th hold edge.
    cyc(1'b0, 2'd2, 1'b0, 1'b0, 8);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 2'd2, 1'b1, 1'b0, 1);
      cyc(1'b0, 2'd2, 1'b0, 1'b0, 1);
    end
    pulses_seen = 0;
    cyc(1'b0, 2'd2, 1'b1, 1'b0, 5);
    check_int("bounce_no_early_pulse", pulses_seen, 0);
    cyc(1'b0, 2'd2, 1'b1, 1'b0, 1);
    check("step_pulse_on_6th", clk_en, 1'b1);
    cyc(1'b0, 2'd2, 1'b1, 1'b0, 4);
    cyc(1'b0, 2'd2, 1'b0, 1'b0, 10);
    check_int("one_pulse_per_press", pulses_seen, 1);

    // Press in stop mode, then step mode with the button released: nothing.
    pulses_seen = 0;
    cyc(1'b0, 2'd3, 1'b1, 1'b0, 8);
    cyc(1'b0, 2'd3, 1'b0, 1'b0, 2);
    cyc(1'b0, 2'd2, 1'b0, 1'b0, 8);
    check_int("no_late_step", pulses_seen, 0);

    // Reset with divider counter at 1; next pulse DIV edges after release.
    cyc(1'b0, 2'd1, 1'b0, 1'b0, 3);
    cyc(1'b1, 2'd1, 1'b0, 1'b0, 1);
    pulses_seen = 0;
    cyc(1'b0, 2'd1, 1'b0, 1'b0, 3);
    check_int("post_reset_quiet", pulses_seen, 0);
    cyc(1'b0, 2'd1, 1'b0, 1'b0, 1);
    check("post_reset_pulse", clk_en, 1'b1);

    // Reset in the middle of a held press: re-debounced, one pulse.
    cyc(1'b0, 2'd2, 1'b1, 1'b0, 3);
    cyc(1'b1, 2'd2, 1'b1, 1'b0, 1);
    pulses_seen = 0;
    cyc(1'b0, 2'd2, 1'b1, 1'b0, 12);
    cyc(1'b0, 2'd2, 1'b0, 1'b0, 8);
    check_int("reset_mid_press_pulse", pulses_seen, 1);

    // Random mode / button / occasional reset traffic.
    for (int seg = 0; seg < 80; seg++) begin
      cyc(($urandom_range(0, 29) == 0) ? 1'b1 : 1'b0, 2'($urandom_range(0, 3)),
          1'($urandom_range(0, 1)), 1'b0, int'($urandom_range(1, 10)));
    end

    // Sticky halt on the DIV=4 instance.
    cyc(1'b1, 2'd0, 1'b0, 1'b0, 1);
    cyc(1'b0, 2'd0, 1'b0, 1'b0, 5);
    cyc(1'b0, 2'd0, 1'b0, 1'b1, 1);
    check("halt_same_edge", halted, 1'b1);
    pulses_seen = 0;
    cyc(1'b0, 2'd0, 1'b0, 1'b0, 3);
    cyc(1'b0, 2'd2, 1'b1, 1'b0, 10);
    cyc(1'b0, 2'd1, 1'b0, 1'b0, 8);
    check_int("halted_no_pulses", pulses_seen, 0);
    cyc(1'b1, 2'd3, 1'b0, 1'b0, 1);

    // DIV_RATIO=1 instance: free-run, halt at edge 20, step ignored, divide every cycle.
    cyc(1'b0, 2'd3, 1'b0, 1'b0, 1);
    check("u1_reset_en", u1_clk_en, 1'b0);
    check("u1_reset_halted", u1_halted, 1'b0);
    u1_rst = 1'b0;
    for (int e = 1; e <= 19; e++) begin
      cyc(1'b0, 2'd3, 1'b0, 1'b0, 1);
      check("u1_run_en", u1_clk_en, 1'b1);
    end
    u1_halt = 1'b1;
    cyc(1'b0, 2'd3, 1'b0, 1'b0, 1);
    check("u1_halt_en", u1_clk_en, 1'b0);
    check("u1_halt_flag", u1_halted, 1'b1);
    u1_halt = 1'b0;
    for (int e = 0; e < 5; e++) begin
      cyc(1'b0, 2'd3, 1'b0, 1'b0, 1);
      check("u1_halted_en", u1_clk_en, 1'b0);
      check("u1_halted_flag", u1_halted, 1'b1);
    end
    u1_mode = 2'd2;
    u1_btn  = 1'b1;
    for (int e = 0; e < 10; e++) begin
      cyc(1'b0, 2'd3, 1'b0, 1'b0, 1);
      check("u1_halted_step", u1_clk_en, 1'b0);
    end
    u1_btn = 1'b0;
    u1_rst = 1'b1;
    cyc(1'b0, 2'd3, 1'b0, 1'b0, 1);
    check("u1_rst_clears_halt", u1_halted, 1'b0);
    u1_rst  = 1'b0;
    u1_mode = 2'd1;
    for (int e = 0; e < 6; e++) begin
      cyc(1'b0, 2'd3, 1'b0, 1'b0, 1);
      check("u1_div1_every_cycle", u1_clk_en, 1'b1);
    end
    u1_mode = 2'd3;
    cyc(1'b0, 2'd3, 1'b0, 1'b0, 1);
    check("u1_stop", u1_clk_en, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
